// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - request/response bus between a requester and data_memory_ctrl
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - byte-addressed little-endian data memory with RISC-V load/store sizes
// One request in flight; loads answer READ_LAT cycles after accept, stores and errors after one.
module data_memory_ctrl #(
  parameter int DEPTH_BYTES = 1024,
  parameter int READ_LAT    = 1
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [1:0]  cnt, cnt_next;
  logic [7:0]  mem [DEPTH_BYTES];

  logic        accept;
  logic        size_bad;
  logic        req_err;
  logic [2:0]  nbytes;
  logic [32:0] last_addr;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [31:0] raw;
  logic [31:0] ext;
  logic [31:0] load_word;
  logic [31:0] hold_data;
  logic        hold_err;

  // Gating with reset keeps ready low while reset is held even though state already reads IDLE.
  assign bus.req_ready  = (state == IDLE) && reset;
  assign bus.resp_valid = (state == RESP);
  assign accept         = bus.req_valid && bus.req_ready;

  always_comb begin
    nbytes   = 3'd1;
    size_bad = 1'b0;
    case (bus.req_size)
      3'b000, 3'b100: nbytes = 3'd1;
      3'b001, 3'b101: nbytes = 3'd2;
      3'b010:         nbytes = 3'd4;
      default:        size_bad = 1'b1;
    endcase
  end

  // Full 33-bit end address so high addresses never alias into the array.
  assign last_addr = {1'b0, bus.req_addr} + 33'(nbytes) - 33'd1;

  assign req_err = size_bad
                || (bus.req_we && bus.req_size[2])
                || ((nbytes == 3'd2) && bus.req_addr[0])
                || ((nbytes == 3'd4) && (bus.req_addr[1:0] != 2'b00))
                || (last_addr >= 33'(DEPTH_BYTES));

  assign a0  = bus.req_addr[AW-1:0];
  assign a1  = a0 + AW'(1);
  assign a2  = a0 + AW'(2);
  assign a3  = a0 + AW'(3);
  assign raw = {mem[a3], mem[a2], mem[a1], mem[a0]};

  always_comb begin
    ext = 32'd0;
    case (bus.req_size)
      3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
      3'b010:  ext = raw;
      3'b100:  ext = {24'd0, raw[7:0]};
      3'b101:  ext = {16'd0, raw[15:0]};
      default: ext = 32'd0;
    endcase
  end

  assign load_word = (req_err || bus.req_we) ? 32'd0 : ext;

  // Memory has no reset so stored data survives a reset pulse.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !req_err) begin
      mem[a0] <= bus.req_wdata[7:0];
      if (nbytes != 3'd1) begin
        mem[a1] <= bus.req_wdata[15:8];
      end
      if (nbytes == 3'd4) begin
        mem[a2] <= bus.req_wdata[23:16];
        mem[a3] <= bus.req_wdata[31:24];
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.req_we || req_err || (READ_LAT == 1)) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 2'(READ_LAT - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt - 2'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= 2'd0;
      hold_data      <= 32'd0;
      hold_err       <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        hold_data <= load_word;
        hold_err  <= req_err;
      end
      if (state_next == RESP) begin
        bus.resp_rdata <= (state == IDLE) ? load_word : hold_data;
        bus.resp_err   <= (state == IDLE) ? req_err   : hold_err;
      end else begin
        bus.resp_rdata <= 32'd0;
        bus.resp_err   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - self-checking bench driving READ_LAT=1 and READ_LAT=3 instances in lockstep
module tb_data_memory_ctrl;
  localparam int DEPTH = 1024;
  localparam logic [31:0] LD_ADDR [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
  localparam logic [2:0]  LD_SIZE [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
  localparam logic [31:0] LD_EXP  [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [7:0] mm [DEPTH];

  data_memory_ctrl_if b1();
  data_memory_ctrl_if b3();

  data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .READ_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .READ_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] s);
    b1.req_valid = v; b1.req_we = we; b1.req_addr = a; b1.req_wdata = d; b1.req_size = s;
    b3.req_valid = v; b3.req_we = we; b3.req_addr = a; b3.req_wdata = d; b3.req_size = s;
  endtask

  // Reference: byte array plus the access rules, with extension done arithmetically.
  function automatic void ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                     input logic [2:0] sz, output logic err, output logic [31:0] rd);
    int n;
    logic [31:0] v;
    n = (sz == 3'b010) ? 4 : ((sz == 3'b001) || (sz == 3'b101)) ? 2 : 1;
    err = (sz == 3'b011) || (sz == 3'b110) || (sz == 3'b111) || (we && sz[2])
       || ((n == 2) && (addr % 2 != 0)) || ((n == 4) && (addr % 4 != 0))
       || (longint'({32'd0, addr}) + longint'(n) - 1 >= longint'(DEPTH));
    rd = 32'd0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < n; k++) mm[int'(addr) + k] = wd[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v + (32'(mm[int'(addr) + k]) << (8 * k));
        if ((sz == 3'b000) && (v >= 32'h80))   v = v - 32'h100;
        if ((sz == 3'b001) && (v >= 32'h8000)) v = v - 32'h1_0000;
        rd = v;
      end
    end
  endfunction

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] sz,
                        output logic [31:0] got1, output logic [31:0] got3,
                        output logic gerr1, output logic gerr3);
    logic eerr;
    logic [31:0] erd;
    logic [31:0] g;
    int lat1, lat3, n1, n3, elat3;
    ref_access(we, addr, wd, sz, eerr, erd);
    elat3 = (!we && !eerr) ? 3 : 1;
    got1 = 32'd0; got3 = 32'd0; gerr1 = 1'b0; gerr3 = 1'b0;
    lat1 = -1; lat3 = -1; n1 = 0; n3 = 0;
    tests_run++;
    if ((b1.req_ready !== 1'b1) || (b3.req_ready !== 1'b1)) begin
      tests_failed++;
      $display("FAIL req_ready_idle: got %b/%b want 1/1", b1.req_ready, b3.req_ready);
    end
    drive(1'b1, we, addr, wd, sz);
    cycle();
    g = $urandom;
    drive(1'b0, g[0], g, $urandom, g[3:1]);
    for (int c = 1; c <= 6; c++) begin
      if (b1.resp_valid === 1'b1) begin
        n1++; lat1 = c; got1 = b1.resp_rdata; gerr1 = b1.resp_err;
      end else begin
        tests_run++;
        if ((b1.resp_rdata !== 32'd0) || (b1.resp_err !== 1'b0)) begin
          tests_failed++;
          $display("FAIL idle_out_lat1: rdata %h err %b want 0 0", b1.resp_rdata, b1.resp_err);
        end
      end
      if (b3.resp_valid === 1'b1) begin
        n3++; lat3 = c; got3 = b3.resp_rdata; gerr3 = b3.resp_err;
      end else begin
        tests_run++;
        if ((b3.resp_rdata !== 32'd0) || (b3.resp_err !== 1'b0)) begin
          tests_failed++;
          $display("FAIL idle_out_lat3: rdata %h err %b want 0 0", b3.resp_rdata, b3.resp_err);
        end
      end
      cycle();
    end
    tests_run++;
    if ((n1 != 1) || (lat1 != 1)) begin
      tests_failed++;
      $display("FAIL pulse_lat1 addr %h: %0d pulses at %0d, want 1 at 1", addr, n1, lat1);
    end
    tests_run++;
    if ((n3 != 1) || (lat3 != elat3)) begin
      tests_failed++;
      $display("FAIL pulse_lat3 addr %h: %0d pulses at %0d, want 1 at %0d", addr, n3, lat3, elat3);
    end
    tests_run++;
    if ((got1 !== erd) || (gerr1 !== eerr)) begin
      tests_failed++;
      $display("FAIL resp_lat1 we %b addr %h sz %b: got %h/%b want %h/%b", we, addr, sz, got1, gerr1, erd, eerr);
    end
    tests_run++;
    if ((got3 !== erd) || (gerr3 !== eerr)) begin
      tests_failed++;
      $display("FAIL resp_lat3 we %b addr %h sz %b: got %h/%b want %h/%b", we, addr, sz, got3, gerr3, erd, eerr);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    reset = 1'b0;
    cycle(); cycle(); cycle();
    tests_run++;
    if ({b1.req_ready, b1.resp_valid, b1.resp_err, b3.req_ready, b3.resp_valid, b3.resp_err} !== 6'b0
        || b1.resp_rdata !== 32'd0 || b3.resp_rdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rdy %b/%b vld %b/%b err %b/%b rdata %h/%h want all 0",
               b1.req_ready, b3.req_ready, b1.resp_valid, b3.resp_valid, b1.resp_err, b3.resp_err,
               b1.resp_rdata, b3.resp_rdata);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ((b1.req_ready !== 1'b1) || (b3.req_ready !== 1'b1)) begin
      tests_failed++;
      $display("FAIL ready_after_reset: got %b/%b want 1/1", b1.req_ready, b3.req_ready);
    end
    cycle();
  endtask

  task automatic test_directed();
    logic [31:0] r1, r3;
    logic e1, e3;
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, r1, r3, e1, e3);
    do_req(1'b0, 32'h10, 32'd0, 3'b010, r1, r3, e1, e3);
    tests_run++;
    if ((r1 !== 32'hDEAD_BEEF) || (r3 !== 32'hDEAD_BEEF) || e1 || e3) begin
      tests_failed++;
      $display("FAIL load_w_10: got %h/%h err %b/%b want deadbeef", r1, r3, e1, e3);
    end
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, LD_ADDR[i], 32'd0, LD_SIZE[i], r1, r3, e1, e3);
      tests_run++;
      if ((r1 !== LD_EXP[i]) || (r3 !== LD_EXP[i])) begin
        tests_failed++;
        $display("FAIL load_ext_%0d: got %h/%h want %h", i, r1, r3, LD_EXP[i]);
      end
    end
    do_req(1'b1, 32'h11, 32'h1234, 3'b001, r1, r3, e1, e3);
    tests_run++;
    if ((e1 !== 1'b1) || (e3 !== 1'b1)) begin
      tests_failed++;
      $display("FAIL misaligned_store_err: got %b/%b want 1/1", e1, e3);
    end
    do_req(1'b0, 32'h10, 32'd0, 3'b010, r1, r3, e1, e3);
    tests_run++;
    if ((r1 !== 32'hDEAD_BEEF) || (r3 !== 32'hDEAD_BEEF)) begin
      tests_failed++;
      $display("FAIL mem_untouched: got %h/%h want deadbeef", r1, r3);
    end
    do_req(1'b1, 32'(DEPTH - 4), 32'hA5A5_0F0F, 3'b010, r1, r3, e1, e3);
    do_req(1'b0, 32'(DEPTH - 4), 32'd0, 3'b010, r1, r3, e1, e3);
    tests_run++;
    if ((e1 !== 1'b0) || (e3 !== 1'b0) || (r3 !== 32'hA5A5_0F0F)) begin
      tests_failed++;
      $display("FAIL top_word: got %h err %b/%b want a5a50f0f err 0", r3, e1, e3);
    end
    do_req(1'b0, 32'(DEPTH), 32'd0, 3'b010, r1, r3, e1, e3);
    tests_run++;
    if ((e1 !== 1'b1) || (e3 !== 1'b1) || (r1 !== 32'd0) || (r3 !== 32'd0)) begin
      tests_failed++;
      $display("FAIL past_end: got %h/%h err %b/%b want 0 err 1", r1, r3, e1, e3);
    end
  endtask

  task automatic test_random();
    logic [31:0] r1, r3, addr;
    logic e1, e3, we;
    logic [2:0] sz;
    logic [2:0] codes [5];
    int r, m;
    codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b010; codes[3] = 3'b100; codes[4] = 3'b101;
    for (int a = 0; a < 256; a += 4) do_req(1'b1, 32'(a), $urandom, 3'b010, r1, r3, e1, e3);
    do_req(1'b1, 32'(DEPTH - 4), $urandom, 3'b010, r1, r3, e1, e3);
    for (int i = 0; i < 150; i++) begin
      we = ($urandom_range(0, 2) == 0);
      r  = $urandom_range(0, 9);
      sz = (r < 8) ? codes[r % 5] : (r == 8) ? 3'b011 : 3'(6 + $urandom_range(0, 1));
      m  = $urandom_range(0, 9);
      addr = (m < 8) ? 32'($urandom_range(0, 255))
           : (m == 8) ? 32'(DEPTH - $urandom_range(0, 4))
           : ($urandom | 32'h1000_0000);
      do_req(we, addr, $urandom, sz, r1, r3, e1, e3);
    end
  endtask

  task automatic test_back_to_back();
    logic eerr, r1, r3, v;
    logic [31:0] erd;
    int acc1, acc3, p1, p3, s1, s3;
    acc1 = 0; acc3 = 0; p1 = 0; p3 = 0; s1 = 99; s3 = 99;
    ref_access(1'b0, 32'h20, 32'd0, 3'b010, eerr, erd);
    drive(1'b1, 1'b0, 32'h20, 32'd0, 3'b010);
    r1 = b1.req_ready; r3 = b3.req_ready; v = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (r1 && v) begin acc1++; s1 = 1; end else s1++;
      if (r3 && v) begin acc3++; s3 = 1; end else s3++;
      if (b1.resp_valid === 1'b1) p1++;
      if (b3.resp_valid === 1'b1) begin
        p3++;
        tests_run++;
        if (b3.resp_rdata !== erd) begin
          tests_failed++;
          $display("FAIL b2b_rdata: got %h want %h", b3.resp_rdata, erd);
        end
      end
      tests_run++;
      if ((s3 >= 1) && (s3 <= 3) && (b3.req_ready !== 1'b0)) begin
        tests_failed++;
        $display("FAIL b2b_ready_low: cycle %0d after accept ready %b want 0", s3, b3.req_ready);
      end
      tests_run++;
      if (b3.resp_valid !== ((s3 == 3) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("FAIL b2b_pulse_lat3: cycle %0d after accept resp_valid %b", s3, b3.resp_valid);
      end
      tests_run++;
      if (b1.resp_valid !== ((s1 == 1) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("FAIL b2b_pulse_lat1: cycle %0d after accept resp_valid %b", s1, b1.resp_valid);
      end
      r1 = b1.req_ready; r3 = b3.req_ready;
      v = (i < 23);
      drive(v, 1'b0, 32'h20, 32'd0, 3'b010);
    end
    tests_run++;
    if ((acc3 != 6) || (p3 != acc3) || (acc1 != 12) || (p1 != acc1)) begin
      tests_failed++;
      $display("FAIL b2b_counts: accepts %0d/%0d pulses %0d/%0d want 12/6 and equal", acc1, acc3, p1, p3);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r1, r3;
    logic e1, e3, eerr;
    logic [31:0] erd;
    do_req(1'b1, 32'h40, 32'h0BAD_F00D, 3'b010, r1, r3, e1, e3);
    drive(1'b1, 1'b0, 32'h40, 32'd0, 3'b010);
    cycle();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    reset = 1'b0;
    #1;
    tests_run++;
    if ((b3.resp_valid !== 1'b0) || (b3.req_ready !== 1'b0)) begin
      tests_failed++;
      $display("FAIL reset_in_wait: vld %b rdy %b want 0 0", b3.resp_valid, b3.req_ready);
    end
    cycle();
    reset = 1'b1;
    #1;
    tests_run++;
    if ((b1.req_ready !== 1'b1) || (b3.req_ready !== 1'b1)) begin
      tests_failed++;
      $display("FAIL ready_after_abort: got %b/%b want 1/1", b1.req_ready, b3.req_ready);
    end
    for (int c = 0; c < 4; c++) begin
      cycle();
      tests_run++;
      if ((b1.resp_valid !== 1'b0) || (b3.resp_valid !== 1'b0)) begin
        tests_failed++;
        $display("FAIL aborted_pulse: cycle %0d vld %b/%b want 0/0", c, b1.resp_valid, b3.resp_valid);
      end
    end
    ref_access(1'b1, 32'h44, 32'h1357_9BDF, 3'b010, eerr, erd);
    drive(1'b1, 1'b1, 32'h44, 32'h1357_9BDF, 3'b010);
    cycle();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    reset = 1'b0;
    #1;
    tests_run++;
    if ((b1.resp_valid !== 1'b0) || (b3.resp_valid !== 1'b0)) begin
      tests_failed++;
      $display("FAIL store_abort_pulse: vld %b/%b want 0/0", b1.resp_valid, b3.resp_valid);
    end
    cycle();
    reset = 1'b1;
    cycle();
    do_req(1'b0, 32'h44, 32'd0, 3'b010, r1, r3, e1, e3);
    tests_run++;
    if ((r1 !== 32'h1357_9BDF) || (r3 !== 32'h1357_9BDF)) begin
      tests_failed++;
      $display("FAIL store_survives_reset: got %h/%h want 13579bdf", r1, r3);
    end
    do_req(1'b0, 32'h40, 32'd0, 3'b010, r1, r3, e1, e3);
    tests_run++;
    if ((r1 !== 32'h0BAD_F00D) || (r3 !== 32'h0BAD_F00D)) begin
      tests_failed++;
      $display("FAIL data_after_reset: got %h/%h want 0badf00d", r1, r3);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
